// File: rtl/bmp_pkg.sv
// Shared sprite bitmap ROM geometry and small helpers for the sprite ROM path.
package bmp_pkg;
  localparam int SPR_W     = 16;
  localparam int SPR_H     = 16;
  localparam int NSPRITES  = 16;
  localparam int ROM_AW    = 12;
  localparam int ROM_DW    = 4;
  localparam int BURST_DEF = SPR_W;

  // Index width that stays legal for n == 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side request/grant/return bus plus the ROM address/pixel port.
interface sprite_rom_arbiter_if
  import bmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ROM_AW,
  parameter int DW   = ROM_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_add;
  logic [DW-1:0]      rom_pixel;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;
  logic               busy;

  modport master (
    output req, req_addr, rom_pixel,
    input  gnt, rom_add, rdata, rvalid, busy
  );

  modport slave (
    input  req, req_addr, rom_pixel,
    output gnt, rom_add, rdata, rvalid, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first requester at or above ptr, modulo N.
module rr_arbiter
  import bmp_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);
  logic          found;
  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    winner = '0;
    j      = 0;
    jj     = '0;
    for (int i = 0; i < N; i++) begin
      j  = (int'(ptr) + i) % N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    if (found) winner[idx] = 1'b1;
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin burst arbiter sharing the sprite bitmap ROM among NREQ engines.
//   state   | meaning
//   S_IDLE  | no burst; arbitrate every cycle, rom_add holds last address
//   S_BURST | issuing base+cnt for owner; re-arbitrate on cnt == BURST-1
module sprite_rom_arbiter
  import bmp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int AW    = ROM_AW,
  parameter int DW    = ROM_DW,
  parameter int BURST = BURST_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(BURST);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]      state;
  logic [IW-1:0]   ptr, owner, owner_d, win_idx;
  logic [NREQ-1:0] win_oh, gnt_r;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   base, add_r, win_addr;
  logic            issued_d;
  logic            arb_pt;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (win_oh),
    .idx    (win_idx)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++)
      if (win_idx == IW'(i)) win_addr = bus.req_addr[i*AW +: AW];
  end

  assign arb_pt = (state == S_IDLE) || (cnt == CW'(BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      owner    <= '0;
      owner_d  <= '0;
      base     <= '0;
      add_r    <= '0;
      gnt_r    <= '0;
      issued_d <= 1'b0;
    end else begin
      // Return-path tag: the ROM answers one cycle after each issued address.
      issued_d <= (state == S_BURST);
      owner_d  <= owner;
      gnt_r    <= '0;
      if (arb_pt && (|bus.req)) begin
        state <= S_BURST;
        owner <= win_idx;
        base  <= win_addr;
        add_r <= win_addr;
        cnt   <= '0;
        gnt_r <= win_oh;
        ptr   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (arb_pt) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + 1'b1;
        add_r <= base + AW'(cnt) + AW'(1);
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.rom_add = add_r;
  assign bus.busy    = (state == S_BURST);
  assign bus.rdata   = bus.rom_pixel;
  assign bus.rvalid  = issued_d ? (NREQ'(1) << owner_d) : '0;
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin burst arbiter that shares the single-port 16-sprite, 4-bit-pixel bitmap ROM among up to NREQ sprite engines. Each requester asks for one sprite row by base address. The arbiter grants one requester at a time, sequences BURST consecutive ROM reads for it, and steers the returned pixels back with a per-requester valid strobe. It sits between the sprite engines and the ROM's 12-bit `add` / 4-bit `pixel` port.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 12, ROM address width
- DW, 4, pixel width
- BURST, 16, reads per grant (one sprite row); must be 2..256
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_addr  in  NREQ*AW  per-requester base address, slice i = bits [i*AW +: AW]
- gnt  out  NREQ  one-hot grant pulse, one cycle
- rom_add  out  AW  address to ROM `add`
- rom_pixel  in  DW  ROM `pixel` output (1-cycle registered read)
- rdata  out  DW  pixel returned to owner (= rom_pixel)
- rvalid  out  NREQ  one-hot, rdata valid for that requester
- busy  out  1  burst in progress

## Operation
- States: IDLE, BURST.
- Arbitration point:
  - any IDLE cycle;
  - last BURST cycle (cnt = BURST-1).
- At an arbitration point with any req high, the winner is the first requester with req high, searching from ptr upward modulo NREQ.
  - On the clock edge: owner<=winner, base<=req_addr[winner], rom_add<=base, cnt<=0, gnt[winner]<=1, ptr<=winner+1 mod NREQ, state<=BURST.
  - With no req high: state<=IDLE, gnt<=0.
- BURST, each cycle:
  - rom_add = base+cnt, modulo 2^AW (wraps, no saturation);
  - cnt increments;
  - issued flag registered with owner tag.
- rvalid[owner_d]=1 in the cycle after each issued address. rdata = rom_pixel combinationally.
- gnt is high only in the first BURST cycle.
- Requester protocol:
  - hold req and req_addr stable until gnt is seen;
  - deassert req by the next cycle unless it wants another burst.
- req dropping before grant withdraws the request with no side effect.
- Back-to-back bursts have no bubble: the pixel stream for the new owner continues immediately after the last pixel of the old owner.
- rvalid is never asserted for two requesters in the same cycle.
- Reset values:
  - state IDLE, ptr 0, cnt 0, owner 0;
  - gnt 0, rom_add 0, rvalid 0, busy 0.
  - In-flight pixel is discarded.
- Reset mid-burst: outputs take reset values immediately (async). The burst is not resumed. Requesters re-request after rst_n rises.
- In IDLE, rom_add holds the last issued address.

## Timing
- Cycle T: IDLE, req[i] high.
- T+1: gnt[i]=1, busy=1, rom_add=base.
- T+1+k: rom_add=base+k, for k=0..BURST-1.
- T+2+k: rvalid[i]=1, rdata=ROM[base+k].
- busy falls after T+BURST unless re-arbitrated.
- rvalid falls after T+1+BURST unless the next burst continues.
- Request-to-first-pixel latency: 2 cycles. Throughput: 1 pixel/cycle.
- Worst-case wait for a requester: (NREQ-1)*BURST cycles.

## Structure
- Shared package `bmp_pkg`:
  - sprite width/height (16), nsprites (16);
  - ROM AW (12), DW (4);
  - BURST default derived as width.
- Sub-module `rr_arbiter` (combinational rotate-priority pick): inputs req and ptr; outputs one-hot winner and index.
- Top holds the FSM, counter, base/owner registers and the return-path tag register.

## Test plan
- Single request: req[2]=1, base 0x120 at T → gnt[2] at T+1; rom_add 0x120..0x12F at T+1..T+16; rvalid[2] at T+2..T+17 with the loaded ROM contents; busy low at T+17.
- Contention: req=4'b1011 from reset → grant order 0,1,3, then 0 again if still requesting. Bursts back-to-back, no rvalid gap, rvalid one-hot throughout.
- Fairness: all four requesters held high for 8 bursts → each granted exactly twice, in order 0,1,2,3,0,1,2,3.
- Wrap-around: base 0xFF8, BURST 16 → rom_add 0xFF8..0xFFF then 0x000..0x007.
- Reset mid-burst: rst_n low at burst cycle 5 → gnt/rvalid/busy/rom_add 0 within the same cycle. After release with req[1] high, a fresh grant to 1 with rom_add starting at base.
- Withdrawn request: req[3] pulses for one cycle while requester 0 owns the bus → requester 3 is never granted and no rvalid[3] is seen.
